// File: rtl/register_file_param_pkg.sv
// Shared types and constants for the parametrised register file and its save/restore sequencer.
package register_file_param_pkg;

  // Save/restore sequencer states
  typedef enum logic [1:0] {
    SEQ_IDLE    = 2'b00,
    SEQ_SAVE    = 2'b01,
    SEQ_RESTORE = 2'b10
  } seq_state_e;

  // Read port 1 override encodings; any value with bit 1 clear means no override
  localparam logic [1:0] SET_NONE   = 2'b00;
  localparam logic [1:0] SET_IMM    = 2'b10;
  localparam logic [1:0] SET_BRANCH = 2'b11;

  // Default special register indices for an 8-entry file
  localparam int unsigned DEF_IMM_IDX    = 1;
  localparam int unsigned DEF_BRANCH_IDX = 7;
  localparam int unsigned ZERO_IDX       = 0;

endpackage

// File: rtl/register_file_param_if.sv
// Decode/ALU-side bus of the register file: write, swap, read and context-switch controls.
interface register_file_param_if #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned RD1_REGS = 4
);
  localparam int unsigned AW  = $clog2(NUM_REGS);
  localparam int unsigned A1W = $clog2(RD1_REGS);

  logic              write_ctrl;
  logic              carry_out;
  logic              swap_ctrl;
  logic [1:0]        set_ctrl;
  logic [AW-1:0]     write_reg;
  logic [DATA_W-1:0] write_val;
  logic [A1W-1:0]    read_reg1;
  logic [AW-1:0]     read_reg2;
  logic              save_req;
  logic              restore_req;
  logic [DATA_W-1:0] read_val1;
  logic [DATA_W-1:0] read_val2;
  logic [DATA_W-1:0] branch_val;
  logic              busy;
  logic              done;

  // Decode side: drives controls, observes read data and sequencer status
  modport master (
    output write_ctrl, carry_out, swap_ctrl, set_ctrl, write_reg, write_val,
    output read_reg1, read_reg2, save_req, restore_req,
    input  read_val1, read_val2, branch_val, busy, done
  );

  // Register file side
  modport slave (
    input  write_ctrl, carry_out, swap_ctrl, set_ctrl, write_reg, write_val,
    input  read_reg1, read_reg2, save_req, restore_req,
    output read_val1, read_val2, branch_val, busy, done
  );

endinterface

// File: rtl/register_file_param_save_seq.sv
// Multi-cycle live<->shadow bank copy sequencer: walks indices 1..NUM_REGS-1, one per cycle.
module regfile_save_seq
  import register_file_param_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_save_req,
  input  logic                        i_restore_req,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_copy_en_c,
  output logic                        o_restore_c,
  output logic [$clog2(NUM_REGS)-1:0] o_idx_c
);
  localparam int unsigned   AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(1);

  seq_state_e    r_state;
  seq_state_e    w_state_next;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_next;
  logic          r_busy;
  logic          r_done;
  logic          w_busy_next;
  logic          w_done_next;

  // State, counter and registered status flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= SEQ_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  // Next state: save wins over restore; stop after copying the last index (no counter wrap)
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      SEQ_IDLE: begin
        w_idx_next = FIRST_IDX;
        if (i_save_req) begin
          w_state_next = SEQ_SAVE;
        end else if (i_restore_req) begin
          w_state_next = SEQ_RESTORE;
        end
      end
      SEQ_SAVE, SEQ_RESTORE: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = SEQ_IDLE;
        end else begin
          w_idx_next = r_idx + AW'(1);
        end
      end
      default: begin
        w_state_next = SEQ_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != SEQ_IDLE);
    w_done_next = (r_state != SEQ_IDLE) && (w_state_next == SEQ_IDLE);
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_copy_en_c = (r_state != SEQ_IDLE);
  assign o_restore_c = (r_state == SEQ_RESTORE);
  assign o_idx_c     = r_idx;

endmodule

// File: rtl/register_file_param.sv
// Parametrised accumulator-datapath register file with carry write, swap, read overrides,
// optional write bypass and a shadow bank for call/return context switching.
module register_file_param
  import register_file_param_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned RD1_REGS   = 4,
  parameter int unsigned IMM_IDX    = DEF_IMM_IDX,
  parameter int unsigned BRANCH_IDX = NUM_REGS - 1,
  parameter int unsigned CARRY_VAL  = 1,
  parameter int unsigned BYPASS     = 0
) (
  input logic                  clock,
  input logic                  reset,
  register_file_param_if.slave bus
);
  localparam int unsigned       AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0]     IMM_A    = AW'(IMM_IDX);
  localparam logic [AW-1:0]     BRANCH_A = AW'(BRANCH_IDX);
  localparam logic [AW-1:0]     ZERO_A   = AW'(ZERO_IDX);
  localparam logic [DATA_W-1:0] CARRY_D  = DATA_W'(CARRY_VAL);

  logic [DATA_W-1:0] r_regs   [NUM_REGS];
  logic [DATA_W-1:0] r_shadow [NUM_REGS];

  logic          w_copy_en;
  logic          w_restore;
  logic [AW-1:0] w_copy_idx;
  logic          w_wr_acc;
  logic [AW-1:0] w_sw_a;
  logic [AW-1:0] w_sw_b;
  logic [AW-1:0] w_rd1_idx;
  logic [AW-1:0] w_rd2_idx;

  // Read data with optional same-cycle forwarding of an accepted write (carry value wins on IMM)
  function automatic logic [DATA_W-1:0] read_port(
    input logic [AW-1:0]     idx,
    input logic [DATA_W-1:0] arr_val,
    input logic              wr_acc,
    input logic              carry,
    input logic [AW-1:0]     wr_idx,
    input logic [DATA_W-1:0] wr_val
  );
    read_port = arr_val;
    if ((BYPASS != 0) && wr_acc && (idx != ZERO_A)) begin
      if (carry && (idx == IMM_A)) begin
        read_port = CARRY_D;
      end else if (idx == wr_idx) begin
        read_port = wr_val;
      end
    end
  endfunction

  regfile_save_seq #(
    .NUM_REGS (NUM_REGS)
  ) u_save_seq (
    .i_clk         (clock),
    .i_rst         (reset),
    .i_save_req    (bus.save_req),
    .i_restore_req (bus.restore_req),
    .o_busy        (bus.busy),
    .o_done        (bus.done),
    .o_copy_en_c   (w_copy_en),
    .o_restore_c   (w_restore),
    .o_idx_c       (w_copy_idx)
  );

  assign w_wr_acc  = bus.write_ctrl & ~w_copy_en;
  assign w_sw_a    = AW'(bus.read_reg1);
  assign w_sw_b    = bus.read_reg2;
  assign w_rd2_idx = bus.read_reg2;

  // Port 1 effective index: set_ctrl override, else low-window index
  always_comb begin
    w_rd1_idx = AW'(bus.read_reg1);
    if (bus.set_ctrl == SET_IMM) begin
      w_rd1_idx = IMM_A;
    end else if (bus.set_ctrl == SET_BRANCH) begin
      w_rd1_idx = BRANCH_A;
    end
  end

  assign bus.read_val1  = read_port(w_rd1_idx, r_regs[w_rd1_idx], w_wr_acc, bus.carry_out,
                                    bus.write_reg, bus.write_val);
  assign bus.read_val2  = read_port(w_rd2_idx, r_regs[w_rd2_idx], w_wr_acc, bus.carry_out,
                                    bus.write_reg, bus.write_val);
  assign bus.branch_val = r_regs[BRANCH_A];

  // Array update: reset > sequencer copy > write > swap; index 0 is never written
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        if (w_copy_en) begin
          if (w_copy_idx == AW'(i)) begin
            if (w_restore) begin
              r_regs[i] <= r_shadow[i];
            end else begin
              r_shadow[i] <= r_regs[i];
            end
          end
        end else if (bus.write_ctrl) begin
          if (bus.carry_out && (AW'(i) == IMM_A)) begin
            r_regs[i] <= CARRY_D;
          end else if (bus.write_reg == AW'(i)) begin
            r_regs[i] <= bus.write_val;
          end
        end else if (bus.swap_ctrl) begin
          if (AW'(i) == w_sw_a) begin
            r_regs[i] <= r_regs[w_sw_b];
          end else if (AW'(i) == w_sw_b) begin
            r_regs[i] <= r_regs[w_sw_a];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench: one instance without and one with write bypass, driven by identical stimulus.
module tb_register_file_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       write_ctrl;
  logic       carry_out;
  logic       swap_ctrl;
  logic [1:0] set_ctrl;
  logic [2:0] write_reg;
  logic [7:0] write_val;
  logic [1:0] read_reg1;
  logic [2:0] read_reg2;
  logic       save_req;
  logic       restore_req;

  int n_checks = 0;
  int n_pass   = 0;
  int bc, dc, fd;

  always #5 clock = ~clock;

  register_file_param_if #(.DATA_W(8), .NUM_REGS(8), .RD1_REGS(4)) if_nb ();
  register_file_param_if #(.DATA_W(8), .NUM_REGS(8), .RD1_REGS(4)) if_bp ();

  assign if_nb.write_ctrl = write_ctrl;   assign if_bp.write_ctrl = write_ctrl;
  assign if_nb.carry_out = carry_out;     assign if_bp.carry_out = carry_out;
  assign if_nb.swap_ctrl = swap_ctrl;     assign if_bp.swap_ctrl = swap_ctrl;
  assign if_nb.set_ctrl = set_ctrl;       assign if_bp.set_ctrl = set_ctrl;
  assign if_nb.write_reg = write_reg;     assign if_bp.write_reg = write_reg;
  assign if_nb.write_val = write_val;     assign if_bp.write_val = write_val;
  assign if_nb.read_reg1 = read_reg1;     assign if_bp.read_reg1 = read_reg1;
  assign if_nb.read_reg2 = read_reg2;     assign if_bp.read_reg2 = read_reg2;
  assign if_nb.save_req = save_req;       assign if_bp.save_req = save_req;
  assign if_nb.restore_req = restore_req; assign if_bp.restore_req = restore_req;

  register_file_param #(.BYPASS(0)) dut_nb (.clock(clock), .reset(reset), .bus(if_nb.slave));
  register_file_param #(.BYPASS(1)) dut_bp (.clock(clock), .reset(reset), .bus(if_bp.slave));

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v, input logic c);
    write_ctrl = 1'b1; write_reg = a; write_val = v; carry_out = c;
    cyc();
    write_ctrl = 1'b0; carry_out = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] e);
    read_reg2 = a;
    @(negedge clock);
    check_val(tag, 16'(if_nb.read_val2), 16'(e));
  endtask

  task automatic pulse(input logic s, input logic r);
    save_req = s; restore_req = r;
    cyc();
    save_req = 1'b0; restore_req = 1'b0;
  endtask

  // Observe a sequence: busy cycles, done cycles, first done slot; optionally write while busy
  task automatic watch(input bit inj, output int b_cnt, output int d_cnt, output int d_first);
    b_cnt = 0; d_cnt = 0; d_first = -1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (if_nb.busy === 1'b1) b_cnt++;
      if (if_nb.done === 1'b1) begin
        d_cnt++;
        if (d_first < 0) d_first = k;
      end
      if (inj && k == 3) begin
        write_ctrl = 1'b1; write_reg = 3'd1; write_val = 8'hAB;
      end else begin
        write_ctrl = 1'b0;
      end
    end
    write_ctrl = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; write_ctrl = 0; carry_out = 0; swap_ctrl = 0; set_ctrl = 2'b00;
    write_reg = 0; write_val = 0; read_reg1 = 0; read_reg2 = 0; save_req = 0; restore_req = 0;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_busy", 16'(if_nb.busy), 16'h0);
    check_val("rst_done", 16'(if_nb.done), 16'h0);
    check_val("rst_branch", 16'(if_nb.branch_val), 16'h0);
    rd_chk("rst_r2", 3'd2, 8'h00);

    // Basic writes and hardwired zero
    wr(3'd2, 8'h5A, 1'b0);
    wr(3'd7, 8'h33, 1'b0);
    wr(3'd0, 8'hFF, 1'b0);
    rd_chk("wr_r2", 3'd2, 8'h5A);
    check_val("wr_branch", 16'(if_nb.branch_val), 16'h33);
    rd_chk("wr_r0", 3'd0, 8'h00);

    // Carry writes
    wr(3'd3, 8'h44, 1'b1);
    rd_chk("carry_r1", 3'd1, 8'h01);
    rd_chk("carry_r3", 3'd3, 8'h44);
    wr(3'd1, 8'h99, 1'b1);
    rd_chk("carry_collide_r1", 3'd1, 8'h01);

    // Swap with branch override on port 1
    wr(3'd2, 8'h11, 1'b0);
    wr(3'd5, 8'h22, 1'b0);
    read_reg1 = 2'd2; read_reg2 = 3'd5; set_ctrl = 2'b11; swap_ctrl = 1'b1;
    @(negedge clock);
    check_val("set_branch_rd1", 16'(if_nb.read_val1), 16'h33);
    cyc();
    swap_ctrl = 1'b0; set_ctrl = 2'b00;
    rd_chk("swap_r2", 3'd2, 8'h22);
    rd_chk("swap_r5", 3'd5, 8'h11);
    read_reg1 = 2'd0; read_reg2 = 3'd3; swap_ctrl = 1'b1;
    cyc();
    swap_ctrl = 1'b0;
    rd_chk("swap_zero_r3", 3'd3, 8'h00);

    // Bypass versus registered visibility
    cyc();
    write_ctrl = 1'b1; write_reg = 3'd3; write_val = 8'h77; read_reg1 = 2'd3;
    @(negedge clock);
    check_val("byp_rd1", 16'(if_bp.read_val1), 16'h77);
    check_val("nobyp_rd1", 16'(if_nb.read_val1), 16'h00);
    cyc();
    write_ctrl = 1'b0;
    @(negedge clock);
    check_val("after_wr_rd1", 16'(if_nb.read_val1), 16'h77);
    cyc();
    wr(3'd1, 8'h99, 1'b0);
    write_ctrl = 1'b1; carry_out = 1'b1; write_reg = 3'd4; write_val = 8'h55; read_reg2 = 3'd1;
    @(negedge clock);
    check_val("byp_carry_rd2", 16'(if_bp.read_val2), 16'h01);
    check_val("nobyp_carry_rd2", 16'(if_nb.read_val2), 16'h99);
    cyc();
    write_ctrl = 1'b0; carry_out = 1'b0;
    rd_chk("carry_r4", 3'd4, 8'h55);
    cyc();
    write_ctrl = 1'b1; write_reg = 3'd0; write_val = 8'hFF; read_reg2 = 3'd0;
    @(negedge clock);
    check_val("byp_r0", 16'(if_bp.read_val2), 16'h00);
    cyc();
    write_ctrl = 1'b0;

    // Save then restore, with a dropped write during restore
    for (int i = 1; i < 8; i++) wr(3'(i), 8'(i), 1'b0);
    pulse(1'b1, 1'b0);
    watch(1'b0, bc, dc, fd);
    check_val("save_busy_cycles", 16'(bc), 16'd7);
    check_val("save_done_cycles", 16'(dc), 16'd1);
    check_val("save_done_slot", 16'(fd), 16'd7);
    for (int i = 1; i < 8; i++) wr(3'(i), 8'hEE, 1'b0);
    rd_chk("overwrite_r4", 3'd4, 8'hEE);
    pulse(1'b0, 1'b1);
    watch(1'b1, bc, dc, fd);
    check_val("rest_busy_cycles", 16'(bc), 16'd7);
    check_val("rest_done_cycles", 16'(dc), 16'd1);
    for (int i = 1; i < 8; i++) rd_chk($sformatf("restore_r%0d", i), 3'(i), 8'(i));

    // Simultaneous requests: save must win
    wr(3'd2, 8'h5C, 1'b0);
    pulse(1'b1, 1'b1);
    watch(1'b0, bc, dc, fd);
    check_val("both_busy_cycles", 16'(bc), 16'd7);
    rd_chk("both_save_r2", 3'd2, 8'h5C);

    // Reset in the third busy cycle
    cyc();
    pulse(1'b1, 1'b0);
    repeat (3) @(negedge clock);
    check_val("busy_cycle3", 16'(if_nb.busy), 16'h1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clock);
    check_val("abort_busy", 16'(if_nb.busy), 16'h0);
    check_val("abort_done", 16'(if_nb.done), 16'h0);
    for (int i = 1; i < 8; i++) rd_chk($sformatf("abort_r%0d", i), 3'(i), 8'h00);
    for (int i = 1; i < 8; i++) wr(3'(i), 8'hEE, 1'b0);
    pulse(1'b0, 1'b1);
    watch(1'b0, bc, dc, fd);
    check_val("shadow_busy_cycles", 16'(bc), 16'd7);
    for (int i = 1; i < 8; i++) rd_chk($sformatf("shadow_r%0d", i), 3'(i), 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised next-generation register file for the accumulator-style datapath.
- Generalises data width and register count, and adds the following:
  - synchronous reset;
  - optional write-to-read bypass;
  - a shadow bank with a multi-cycle save/restore sequencer for call/return context switching.
- Sits between decode and the ALU. Port 1 reads the low register window; port 2 reads all registers. Keeps the immediate-register carry write, swap and set-override read behaviour.

Parameters:
- DATA_W, 8, register width in bits
- NUM_REGS, 8, register count; power of 2, at least 4; AW = log2(NUM_REGS)
- RD1_REGS, 4, registers visible to read port 1; power of 2, at most NUM_REGS; A1W = log2(RD1_REGS)
- IMM_IDX, 1, index of the immediate register
- BRANCH_IDX, NUM_REGS-1, index of the branch register
- CARRY_VAL, 1, value loaded into the immediate register on a carry write
- BYPASS, 0, 1 = read ports forward same-cycle write data

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- write_ctrl  in  1  write enable
- carry_out  in  1  carry flag qualifying a write
- swap_ctrl  in  1  swap the two read-selected registers
- set_ctrl  in  2  read port 1 override: 1x selects imm (x=0) or branch (x=1)
- write_reg  in  AW  write index
- write_val  in  DATA_W  write data
- read_reg1  in  A1W  port 1 index
- read_reg2  in  AW  port 2 index
- save_req  in  1  start copy of the live bank into the shadow bank
- restore_req  in  1  start copy of the shadow bank into the live bank
- read_val1  out  DATA_W  port 1 data
- read_val2  out  DATA_W  port 2 data
- branch_val  out  DATA_W  always r[BRANCH_IDX]
- busy  out  1  sequencer active
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - all r[i], all shadow[i], state and counter go to 0;
  - busy=0, done=0;
  - overrides everything, including mid-sequence; an aborted save/restore leaves no partial effect because both banks are cleared.
- r[0] is hardwired zero: writes, swaps and restores to index 0 are dropped.
- Reads are combinational from the live array:
  - set_ctrl=10 gives read_val1=r[IMM_IDX]; set_ctrl=11 gives r[BRANCH_IDX]; otherwise r[read_reg1];
  - read_val2=r[read_reg2].
- BYPASS=1:
  - if write_ctrl is accepted and write_reg (nonzero) matches a port's effective index, that port returns write_val;
  - carry writes forward CARRY_VAL on IMM_IDX.
- BYPASS=0: new values are visible from the cycle after the edge.
- Update priority per edge: reset > sequencer busy > write_ctrl > swap_ctrl.
- Write (write_ctrl=1, not busy):
  - carry_out=0: r[write_reg] <= write_val.
  - carry_out=1: r[IMM_IDX] <= CARRY_VAL. r[write_reg] <= write_val only if write_reg is not IMM_IDX; when they collide, the carry value wins.
- Swap (swap_ctrl=1, write_ctrl=0, not busy):
  - r[read_reg1] and r[read_reg2] exchange pre-edge array values; set_ctrl is ignored for the swap;
  - equal indices give no change; if either index is 0, the other register is loaded with 0.
- Sequencer FSM, states IDLE, SAVE, RESTORE:
  - IDLE: save_req moves to SAVE; restore_req moves to RESTORE; if both are high, save wins. idx <= 1.
  - SAVE: each edge does shadow[idx] <= r[idx] and idx++. After copying NUM_REGS-1, return to IDLE and pulse done for 1 cycle.
  - RESTORE: same sequence with r[idx] <= shadow[idx].
  - busy=1 in SAVE/RESTORE, i.e. NUM_REGS-1 cycles starting the cycle after the request edge. done is high in the first IDLE cycle after busy falls.
  - Requests while busy are ignored (not queued). A request during the done cycle is accepted.
  - write_ctrl and swap_ctrl while busy are dropped; the core stalls on busy. Reads stay live throughout.
- The counter is AW bits wide; termination is compared against NUM_REGS-1, so there is no wrap.

Decomposition:
- Shared package holds:
  - sequencer state enum (IDLE/SAVE/RESTORE);
  - set_ctrl encodings (SET_NONE, SET_IMM=2'b10, SET_BRANCH=2'b11);
  - localparams for default IMM_IDX, BRANCH_IDX and ZERO_IDX=0.
- One sub-module is natural: regfile_save_seq, which holds the FSM, index counter, busy and done, and emits per-cycle copy enable, direction and index. The register arrays stay in the top.

Test Plan:
- Reset, then write r2=0x5A, r7=0x33 -> read_reg2=2 gives 0x5A; branch_val=0x33; writing r0=0xFF leaves read_reg2=0 at 0x00.
- write_ctrl=1, carry_out=1, write_reg=3, write_val=0x44 -> r1=0x01, r3=0x44. Repeat with write_reg=1, write_val=0x99 -> r1=0x01.
- r2=0x11, r5=0x22, swap read_reg1=2, read_reg2=5 -> r2=0x22, r5=0x11. With set_ctrl=11 and r7=0x33, read_val1=0x33 while the swap still uses r2.
- BYPASS=1: write r3=0x77 with read_reg1=3 in the same cycle -> read_val1=0x77 before the edge. BYPASS=0 -> old value shown.
- Load r1..r7=0x01..0x07, save_req -> busy high 7 cycles, done 1 cycle. Overwrite r1..r7=0xEE, restore_req -> after done, r1..r7=0x01..0x07. A write issued while busy has no effect.
- save_req with restore_req in the same cycle -> SAVE runs. Assert reset at the 3rd busy cycle -> next cycle busy=0, done=0, all registers and shadow=0.
